// File: rtl/spike_isi_encoder.sv
// Spike detector with threshold/re-arm hysteresis, inter-spike interval
// measurement in valid samples, and a show-ahead ISI FIFO drained through a
// valid/ready handshake. Also keeps a wrapping spike counter and a sticky
// overflow flag.
//
// Detector states
//   state | meaning
//   ARMED | waiting for v_in >= THRESH; a valid sample at/above it is a spike
//   FIRED | spike seen; waiting for v_in <= REARM before another can fire
module spike_isi_encoder #(
   parameter logic signed [7:0] THRESH = 8'sh40,
   parameter logic signed [7:0] REARM  = 8'shC0,
   parameter int                ISI_W  = 16,
   parameter int                DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_valid,
   input  logic [7:0]       v_in,
   output logic             spike_o,
   output logic [ISI_W-1:0] isi_data,
   output logic             isi_valid,
   input  logic             isi_ready,
   output logic [15:0]      spike_count,
   output logic             overflow
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam int               OCC_W    = $clog2(DEPTH + 1);
   localparam logic [ISI_W-1:0] ISI_MAX  = '1;
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   typedef enum logic {
      ARMED = 1'b0,
      FIRED = 1'b1
   } det_state_t;

   det_state_t       state_q, state_d;
   logic             spike_ev;
   logic [ISI_W-1:0] cnt_q;
   logic [ISI_W-1:0] cnt_sat_inc;
   logic             seen_q;
   logic [ISI_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0] occ_q;
   logic             push, pop, wr_en, drop;

   // Detector next-state; a spike event is the ARMED -> FIRED transition.
   always_comb begin
      state_d  = state_q;
      spike_ev = 1'b0;
      if (sample_valid) begin
         case (state_q)
            ARMED: begin
               if ($signed(v_in) >= THRESH) begin
                  spike_ev = 1'b1;
                  state_d  = FIRED;
               end
            end
            FIRED: begin
               if ($signed(v_in) <= REARM) begin
                  state_d = ARMED;
               end
            end
         endcase
      end
   end

   // Detector state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ARMED;
      end else begin
         state_q <= state_d;
      end
   end

   // Saturating increment doubles as the ISI value on a spike sample.
   assign cnt_sat_inc = (cnt_q == ISI_MAX) ? ISI_MAX : cnt_q + ISI_W'(1);

   // ISI counter and first-spike flag; the first spike only starts timing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         seen_q <= 1'b0;
      end else if (sample_valid) begin
         if (spike_ev) begin
            cnt_q  <= '0;
            seen_q <= 1'b1;
         end else begin
            cnt_q  <= cnt_sat_inc;
         end
      end
   end

   // A pop frees a slot in the same cycle, so a full FIFO still accepts.
   assign isi_valid = (occ_q != '0);
   assign pop       = isi_valid && isi_ready;
   assign push      = spike_ev && seen_q;
   assign wr_en     = push && ((occ_q != OCC_FULL) || pop);
   assign drop      = push && (occ_q == OCC_FULL) && !pop;
   assign isi_data  = isi_valid ? mem[rd_ptr_q] : '0;

   // FIFO storage; contents need no reset because occupancy gates the head.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= cnt_sat_inc;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // Spike pulse, running spike count and sticky overflow.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spike_o     <= 1'b0;
         spike_count <= '0;
         overflow    <= 1'b0;
      end else begin
         spike_o <= spike_ev;
         if (spike_ev) begin
            spike_count <= spike_count + 16'd1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spike_isi_encoder.sv
// Bench for spike_isi_encoder: a vector table for detection/ISI behaviour,
// an ISI scoreboard popped on each handshake, and hand-written sequences for
// FIFO overflow, simultaneous push/pop when full, saturation and reset.
module tb_spike_isi_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_valid;
   logic [7:0]  v_in;
   logic        isi_ready;
   logic        spike_o;
   logic [15:0] isi_data;
   logic        isi_valid;
   logic [15:0] spike_count;
   logic        overflow;
   logic        spike_o_s;
   logic [3:0]  isi_data_s;
   logic        isi_valid_s;
   logic [15:0] spike_count_s;
   logic        overflow_s;

   always #5 clk = ~clk;

   spike_isi_encoder dut (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .v_in(v_in),
      .spike_o(spike_o), .isi_data(isi_data), .isi_valid(isi_valid),
      .isi_ready(isi_ready), .spike_count(spike_count), .overflow(overflow)
   );

   spike_isi_encoder #(.ISI_W(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .v_in(v_in),
      .spike_o(spike_o_s), .isi_data(isi_data_s), .isi_valid(isi_valid_s),
      .isi_ready(isi_ready), .spike_count(spike_count_s), .overflow(overflow_s)
   );

   typedef struct {
      logic       valid;
      logic [7:0] v;
      logic       exp_spike;
      int         exp_isi;
   } vec_t;

   vec_t tbl[$];
   int   exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock: score any handshake happening at this edge, then advance.
   task automatic cyc();
      int e;
      if (rst_n && isi_valid && isi_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_pop", isi_data, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("sb_isi_data", isi_data, e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      sample_valid = 1'b0;
      v_in = 8'h00;
      for (int k = 0; k < n; k++) cyc();
      rst_n = 1'b1;
      exp_q.delete();
      exp_count = 0;
   endtask

   task automatic add(input logic valid, input logic [7:0] v, input logic sp, input int isi);
      vec_t r;
      r.valid = valid; r.v = v; r.exp_spike = sp; r.exp_isi = isi;
      tbl.push_back(r);
   endtask

   // Spike after 'isi' valid samples since the last one (0: no re-arm prefix).
   task automatic do_spike(input int isi, input bit enq, input bit rdy_at_spike);
      logic saved;
      sample_valid = 1'b1;
      if (isi > 0) begin
         v_in = 8'hC0;
         cyc();
         for (int k = 0; k < isi - 2; k++) begin
            v_in = 8'h00;
            cyc();
         end
      end
      saved = isi_ready;
      isi_ready = rdy_at_spike;
      v_in = 8'h50;
      if (enq) exp_q.push_back(isi);
      cyc();
      isi_ready = saved;
      sample_valid = 1'b0;
      v_in = 8'h00;
      exp_count++;
      check("do_spike_pulse", spike_o, 1);
      check("do_spike_count", spike_count, exp_count);
   endtask

   task automatic drain();
      int k;
      k = 0;
      sample_valid = 1'b0;
      isi_ready = 1'b1;
      while (isi_valid && k < 20) begin
         cyc();
         k++;
      end
      check("drain_valid_low", isi_valid, 0);
      check("drain_sb_empty", exp_q.size(), 0);
      isi_ready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; sample_valid = 1'b0; v_in = 8'h00; isi_ready = 1'b0;

      // Reset state and idle samples
      do_reset(2);
      check("rst_spike_o", spike_o, 0);
      check("rst_isi_valid", isi_valid, 0);
      check("rst_isi_data", isi_data, 0);
      check("rst_spike_count", spike_count, 0);
      check("rst_overflow", overflow, 0);
      sample_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("idle_spike_o", spike_o, 0);
         check("idle_isi_valid", isi_valid, 0);
      end

      // First spike: counted, not enqueued
      v_in = 8'h50;
      cyc();
      exp_count = 1;
      check("first_spike_o", spike_o, 1);
      check("first_spike_count", spike_count, 1);
      check("first_isi_valid", isi_valid, 0);

      // Vector table: ISI measurement, hysteresis, thresholds, gating
      add(1, 8'hB0, 0, 0);
      add(1, 8'h50, 1, 2);
      add(1, 8'hB0, 0, 0);
      for (int i = 0; i < 5; i++) add(1, 8'h00, 0, 0);
      add(1, 8'h50, 1, 7);
      add(1, 8'hC0, 0, 0);
      add(1, 8'h50, 1, 2);
      add(1, 8'h48, 0, 0);
      add(1, 8'h30, 0, 0);
      add(1, 8'h50, 0, 0);
      add(1, 8'hC0, 0, 0);
      add(1, 8'h50, 1, 5);
      add(1, 8'hC1, 0, 0);
      add(1, 8'h50, 0, 0);
      add(1, 8'hC0, 0, 0);
      add(1, 8'h3F, 0, 0);
      add(1, 8'h40, 1, 5);
      add(1, 8'hC0, 0, 0);
      for (int i = 0; i < 6; i++) add(0, 8'h50, 0, 0);
      add(1, 8'h00, 0, 0);
      add(1, 8'h00, 0, 0);
      add(1, 8'h50, 1, 4);

      isi_ready = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         sample_valid = tbl[i].valid;
         v_in = tbl[i].v;
         if (tbl[i].exp_isi != 0) exp_q.push_back(tbl[i].exp_isi);
         cyc();
         if (tbl[i].exp_spike) exp_count++;
         check($sformatf("tbl%0d_spike_o", i), spike_o, tbl[i].exp_spike);
         check($sformatf("tbl%0d_count", i), spike_count, exp_count);
      end
      sample_valid = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      check("tbl_sb_empty", exp_q.size(), 0);
      check("tbl_isi_valid", isi_valid, 0);
      check("tbl_overflow", overflow, 0);
      isi_ready = 1'b0;

      // FIFO full: fifth ISI dropped, overflow set, order preserved
      do_reset(1);
      do_spike(0, 0, 0);
      do_spike(3, 1, 0);
      do_spike(4, 1, 0);
      do_spike(5, 1, 0);
      do_spike(6, 1, 0);
      check("full_no_ovf_yet", overflow, 0);
      do_spike(7, 0, 0);
      check("full_overflow", overflow, 1);
      check("full_head", isi_data, 3);
      drain();
      check("ovf_sticky", overflow, 1);

      // Full with pop coinciding with push: nothing lost
      do_reset(1);
      check("reset_clears_ovf", overflow, 0);
      do_spike(0, 0, 0);
      do_spike(3, 1, 0);
      do_spike(4, 1, 0);
      do_spike(5, 1, 0);
      do_spike(6, 1, 0);
      do_spike(7, 1, 1);
      check("pp_overflow", overflow, 0);
      check("pp_head", isi_data, 4);
      drain();

      // Saturation: 40-sample gap is 40 at 16 bits, 15 at 4 bits
      do_reset(1);
      do_spike(0, 0, 0);
      do_spike(40, 1, 0);
      check("sat_isi16", isi_data, 40);
      check("sat_isi4", isi_data_s, 15);
      check("sat_valid4", isi_valid_s, 1);
      drain();

      // Mid-operation reset with two entries queued and ready high
      do_reset(1);
      do_spike(0, 0, 0);
      do_spike(3, 1, 0);
      do_spike(4, 1, 0);
      check("mid_valid_before", isi_valid, 1);
      isi_ready = 1'b1;
      rst_n = 1'b0;
      cyc();
      check("mid_isi_valid", isi_valid, 0);
      check("mid_isi_data", isi_data, 0);
      check("mid_spike_count", spike_count, 0);
      rst_n = 1'b1;
      exp_q.delete();
      exp_count = 0;
      cyc();
      check("mid_after_valid", isi_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_isi_encoder.md
# spike_isi_encoder

Downstream consumer of the Izhikevich neuron core's 8-bit membrane-voltage output (signed, 2 integer + 6 fraction bits). Detects spikes with threshold/re-arm hysteresis and emits a one-cycle spike pulse. Measures the inter-spike interval (ISI) in valid samples and buffers ISIs in a small show-ahead FIFO, read through a valid/ready handshake. Also keeps a running spike count and a sticky overflow flag for the readout logic.

## Interface
- THRESH, 8'sh40 (+1.0): signed spike threshold; a spike fires when v_in >= THRESH while armed.
- REARM, 8'shC0 (-1.0): signed re-arm level; the detector re-arms when v_in <= REARM while fired. Must satisfy REARM < THRESH.
- ISI_W, 16: ISI counter and FIFO data width.
- DEPTH, 4: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sample_valid  in  1  v_in holds a new neuron sample this cycle; tied to the core's enable.
- v_in  in  8  signed membrane voltage sample.
- spike_o  out  1  one-cycle pulse per detected spike.
- isi_data  out  ISI_W  FIFO head entry.
- isi_valid  out  1  FIFO not empty.
- isi_ready  in  1  consumer accepts the head entry when isi_valid && isi_ready.
- spike_count  out  16  spikes detected since reset; wraps at 65535 -> 0.
- overflow  out  1  sticky; set when an ISI is dropped because the FIFO is full.

## Operation
- Detector FSM has two states:
  - ARMED (reset state): on sample_valid with v_in >= THRESH (signed compare), a spike event occurs and the FSM moves to FIRED.
  - FIRED: on sample_valid with v_in <= REARM, the FSM moves to ARMED. Samples above REARM keep it in FIRED, so no retrigger.
- When sample_valid = 0, the FSM, counters and flags hold. FIFO pops still proceed.
- ISI counter `cnt` (ISI_W bits):
  - On each valid sample without a spike event, cnt = min(cnt+1, 2^ISI_W-1).
  - On a spike event, ISI = min(cnt+1, 2^ISI_W-1), then cnt clears to 0.
  - ISI is therefore the number of valid samples from the previous spike sample (exclusive) to the current one (inclusive).
- First-spike rule: flag `seen` resets to 0. The first spike after reset sets `seen`, clears cnt, and does not enqueue. Every later spike enqueues its ISI.
- FIFO behaviour:
  - Show-ahead: isi_data is always the head entry; isi_data is 0 when empty.
  - Push happens on an enqueuing spike event.
  - Pop happens on isi_valid && isi_ready.
  - Full with push and pop in the same cycle: both succeed and the count is unchanged.
  - Full with push and no pop: the ISI is dropped and overflow is set.
  - Empty with push and pop in the same cycle: only the push takes effect, because isi_valid was 0 so there is no pop.
  - Pointers wrap modulo DEPTH. Occupancy is tracked with a separate counter 0..DEPTH.
- spike_count increments on every spike event, including the first.
- overflow clears only on reset.

## Timing
- Reset values, after the first rising edge with rst_n = 0:
  - FSM = ARMED, cnt = 0, seen = 0, FIFO empty.
  - spike_o = 0, isi_valid = 0, isi_data = 0, spike_count = 0, overflow = 0.
- Reset asserted mid-operation discards all FIFO contents and state on that edge. isi_valid drops in the following cycle, irrespective of isi_ready.
- Latency: the spike sample is presented in cycle N.
  - In cycle N+1, spike_o = 1 for exactly one cycle and spike_count is updated.
  - In cycle N+1, the new ISI is visible; isi_valid = 1 and isi_data = ISI if the FIFO was empty.
- A pop in cycle M exposes the next entry, or deasserts isi_valid, in cycle M+1.
- isi_data and isi_valid come from registers only. They have no combinational path from isi_ready, v_in or sample_valid.
- Minimum spike spacing is 2 valid samples: one sample >= THRESH, then one sample <= REARM, then the next sample can fire. So the minimum ISI is 2.
- A sample with v_in >= THRESH that immediately follows a re-arm sample fires. A single sample cannot both re-arm and fire.

## Test plan
- Reset / first spike:
  - Hold rst_n = 0 for 2 cycles, then drive v_in = 0x00 valid for 10 cycles -> all outputs 0.
  - Then drive one sample 0x50 -> spike_o pulses in the next cycle, spike_count = 1, isi_valid remains 0.
- ISI measurement:
  - Spikes at valid samples 0 and 7 (0x50, with re-arm sample 0xB0 at sample 1, v_in = 0x00 elsewhere), isi_ready = 1 -> one entry isi_data = 7, and isi_valid is high for one cycle.
- Hysteresis:
  - Sequence 0x50, 0x48, 0x30, 0x50, 0xC0, 0x50 -> exactly 2 spikes.
  - The ISI enqueued for the second spike is 5.
- Sample gating:
  - Between two spikes 4 valid samples apart, insert 6 cycles with sample_valid = 0 holding v_in = 0x50 -> ISI = 4 and no extra spike.
- FIFO full and overflow:
  - With isi_ready = 0, generate 6 spikes with ISIs 3,4,5,6,7 -> FIFO holds 3,4,5,6 and overflow = 1.
  - Raise isi_ready -> entries drain in order 3,4,5,6, then isi_valid = 0.
  - Repeat with a pop coinciding with the push while full -> no loss, overflow stays 0.
- Saturation and mid-operation reset:
  - ISI_W = 4, spikes 40 samples apart -> ISI = 15.
  - Assert rst_n = 0 with 2 entries queued -> isi_valid = 0 in the next cycle, spike_count = 0.
